// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped BTB: combinational fetch lookup, execute-stage update.
// Optional update/mispredict counters are compiled in with BP_STATS_EN.
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PCF_i,
    output logic                  PredictTakenF_o,
    output logic [DATA_WIDTH-1:0] PredictTargetF_o,
    input  logic                  UpdateE_i,
    input  logic [DATA_WIDTH-1:0] PCE_i,
    input  logic                  ActualTakenE_i,
    input  logic [DATA_WIDTH-1:0] ActualTargetE_i,
    input  logic                  MispredictE_i,
    output logic [31:0]           UpdateCount_o,
    output logic [31:0]           MispredictCount_o
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    logic [ENTRIES-1:0]    valid_q;
    logic [1:0]            ctr_q [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_q [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0]   tag_f, tag_e;
    logic                  hit_f, hit_e;
    logic [1:0]            ctr_d;

    assign idx_f = PCF_i[INDEX_BITS+1:2];
    assign tag_f = PCF_i[TAG_HI:TAG_LO];
    assign idx_e = PCE_i[INDEX_BITS+1:2];
    assign tag_e = PCE_i[TAG_HI:TAG_LO];

    assign hit_f            = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredictTakenF_o  = hit_f && ctr_q[idx_f][1];
    assign PredictTargetF_o = PredictTakenF_o ? tgt_q[idx_f] : PCF_i + DATA_WIDTH'(4);

    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    always_comb begin
        ctr_d = ctr_q[idx_e];
        if (ActualTakenE_i) begin
            if (ctr_q[idx_e] != ST) ctr_d = ctr_q[idx_e] + 2'd1;
        end else begin
            if (ctr_q[idx_e] != SNT) ctr_d = ctr_q[idx_e] - 2'd1;
        end
    end

    // Valid and counters reset; a miss that is taken allocates at WT over any alias.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
        end else if (UpdateE_i) begin
            if (hit_e) begin
                ctr_q[idx_e] <= ctr_d;
            end else if (ActualTakenE_i) begin
                valid_q[idx_e] <= 1'b1;
                ctr_q[idx_e]   <= WT;
            end
        end
    end

    // Tag/target need no reset: they are only observed through a valid entry.
    always_ff @(posedge clk) begin
        if (!rst && UpdateE_i && ActualTakenE_i) begin
            tgt_q[idx_e] <= ActualTargetE_i;
            tag_q[idx_e] <= tag_e;
        end
    end

    logic unused_pce;
    assign unused_pce = ^{PCE_i[1:0], PCF_i[1:0]};

`ifdef BP_STATS_EN
    logic [31:0] upd_cnt_q, upd_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    assign upd_cnt_d = upd_cnt_q + (UpdateE_i ? 32'd1 : 32'd0);
    assign mis_cnt_d = mis_cnt_q + ((UpdateE_i && MispredictE_i) ? 32'd1 : 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            upd_cnt_q <= upd_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign UpdateCount_o     = upd_cnt_q;
    assign MispredictCount_o = mis_cnt_q;
`else
    logic unused_misp;
    assign unused_misp       = MispredictE_i;
    assign UpdateCount_o     = '0;
    assign MispredictCount_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup expectations queued at drive time, checked at sample time.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF_i;
    logic        PredictTakenF_o;
    logic [31:0] PredictTargetF_o;
    logic        UpdateE_i;
    logic [31:0] PCE_i;
    logic        ActualTakenE_i;
    logic [31:0] ActualTargetE_i;
    logic        MispredictE_i;
    logic [31:0] UpdateCount_o;
    logic [31:0] MispredictCount_o;

    branch_predictor dut (
        .clk               (clk),
        .rst               (rst),
        .PCF_i             (PCF_i),
        .PredictTakenF_o   (PredictTakenF_o),
        .PredictTargetF_o  (PredictTargetF_o),
        .UpdateE_i         (UpdateE_i),
        .PCE_i             (PCE_i),
        .ActualTakenE_i    (ActualTakenE_i),
        .ActualTargetE_i   (ActualTargetE_i),
        .MispredictE_i     (MispredictE_i),
        .UpdateCount_o     (UpdateCount_o),
        .MispredictCount_o (MispredictCount_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_upd  = 0;
    int          n_mis  = 0;

    function automatic void push(string tag, logic taken, logic [31:0] tgt);
        exp_t e;
        e.tag = tag; e.taken = taken; e.tgt = tgt;
        sb.push_back(e);
    endfunction

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        n_chk++;
        assert (PredictTakenF_o === e.taken) else begin
            n_fail++;
            $error("FAIL %s taken: got %b exp %b", e.tag, PredictTakenF_o, e.taken);
        end
        n_chk++;
        assert (PredictTargetF_o === e.tgt) else begin
            n_fail++;
            $error("FAIL %s target: got %h exp %h", e.tag, PredictTargetF_o, e.tgt);
        end
    endtask

    task automatic lookup(string tag, logic [31:0] pc, logic taken, logic [31:0] tgt);
        @(negedge clk);
        PCF_i = pc;
        push(tag, taken, tgt);
        #2 pop_check();
    endtask

    task automatic update(logic [31:0] pc, logic taken, logic [31:0] tgt, logic misp);
        @(negedge clk);
        UpdateE_i = 1'b1; PCE_i = pc; ActualTakenE_i = taken;
        ActualTargetE_i = tgt; MispredictE_i = misp;
        n_upd++;
        if (misp) n_mis++;
        @(negedge clk);
        UpdateE_i = 1'b0; MispredictE_i = 1'b0;
    endtask

    task automatic check_stats(string tag, int eu, int em);
`ifdef BP_STATS_EN
        logic [31:0] xu = 32'(eu);
        logic [31:0] xm = 32'(em);
`else
        logic [31:0] xu = (eu < 0) ? 32'hFFFF_FFFF : 32'd0;
        logic [31:0] xm = (em < 0) ? 32'hFFFF_FFFF : 32'd0;
`endif
        n_chk++;
        assert (UpdateCount_o === xu) else begin
            n_fail++;
            $error("FAIL %s updcnt: got %0d exp %0d", tag, UpdateCount_o, xu);
        end
        n_chk++;
        assert (MispredictCount_o === xm) else begin
            n_fail++;
            $error("FAIL %s miscnt: got %0d exp %0d", tag, MispredictCount_o, xm);
        end
    endtask

    initial begin
        rst = 1'b1; PCF_i = 32'h100; UpdateE_i = 1'b0; PCE_i = '0;
        ActualTakenE_i = 1'b0; ActualTargetE_i = '0; MispredictE_i = 1'b0;
        push("rst_hold", 1'b0, 32'h104);
        #2 pop_check();
        check_stats("rst_hold", 0, 0);
        @(negedge clk); rst = 1'b0;
        lookup("rst_rel", 32'h100, 1'b0, 32'h104);

        // allocate and walk the counter through both saturation points
        update(32'h100, 1'b1, 32'h40, 1'b1);
        lookup("alloc", 32'h100, 1'b1, 32'h40);
        update(32'h100, 1'b0, 32'h0, 1'b1);
        lookup("wt_wnt", 32'h100, 1'b0, 32'h104);
        update(32'h100, 1'b0, 32'h0, 1'b0);
        update(32'h100, 1'b0, 32'h0, 1'b0);
        lookup("snt_sat", 32'h100, 1'b0, 32'h104);
        update(32'h100, 1'b1, 32'h40, 1'b0);
        lookup("snt_wnt", 32'h100, 1'b0, 32'h104);
        update(32'h100, 1'b1, 32'h40, 1'b1);
        lookup("wnt_wt", 32'h100, 1'b1, 32'h40);
        update(32'h100, 1'b1, 32'h40, 1'b0);
        update(32'h100, 1'b1, 32'h44, 1'b0);
        lookup("st_tgt", 32'h100, 1'b1, 32'h44);
        update(32'h100, 1'b0, 32'h0, 1'b0);
        lookup("st_wt", 32'h100, 1'b1, 32'h44);
        update(32'h100, 1'b0, 32'h0, 1'b0);
        lookup("wt_wnt2", 32'h100, 1'b0, 32'h104);

        // aliasing on index 0
        lookup("alias_miss", 32'h200, 1'b0, 32'h204);
        update(32'h200, 1'b1, 32'h80, 1'b0);
        lookup("alias_new", 32'h200, 1'b1, 32'h80);
        lookup("alias_old", 32'h100, 1'b0, 32'h104);

        // no update when UpdateE_i is low; miss+not-taken allocates nothing
        @(negedge clk);
        PCE_i = 32'h300; ActualTakenE_i = 1'b1; ActualTargetE_i = 32'h90;
        lookup("no_upd", 32'h300, 1'b0, 32'h304);
        update(32'h400, 1'b0, 32'h0, 1'b0);
        lookup("miss_nt", 32'h400, 1'b0, 32'h404);

        // same-cycle lookup and update: no bypass
        update(32'h104, 1'b1, 32'h50, 1'b0);
        update(32'h104, 1'b0, 32'h0, 1'b0);
        lookup("wnt_pre", 32'h104, 1'b0, 32'h108);
        @(negedge clk);
        PCF_i = 32'h104; UpdateE_i = 1'b1; PCE_i = 32'h104;
        ActualTakenE_i = 1'b1; ActualTargetE_i = 32'h50; MispredictE_i = 1'b1;
        n_upd++; n_mis++;
        push("same_cyc", 1'b0, 32'h108);
        #2 pop_check();
        @(negedge clk);
        UpdateE_i = 1'b0; MispredictE_i = 1'b0;
        push("next_cyc", 1'b1, 32'h50);
        #2 pop_check();

        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        check_stats("stats", n_upd, n_mis);

        // async reset mid-cycle with an update pending over the edge
        @(negedge clk);
        UpdateE_i = 1'b1; PCE_i = 32'h500; ActualTakenE_i = 1'b1; ActualTargetE_i = 32'hA0;
        PCF_i = 32'h200;
        #2 rst = 1'b1;
        push("rst_async", 1'b0, 32'h204);
        #1 pop_check();
        check_stats("rst_async", 0, 0);
        @(negedge clk);
        UpdateE_i = 1'b0; rst = 1'b0;
        lookup("rst_lost", 32'h500, 1'b0, 32'h504);
        lookup("rst_104", 32'h104, 1'b0, 32'h108);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1, "timeout");
    end
endmodule
